// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin time-sharing of one up-counter between two interval requesters
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic             winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            owner_q <= 1'b0;
            tc_q    <= '0;
            count_q <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            tc_q    <= tc_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        tc_d    = tc_q;
        count_d = count_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        // With both requesting, the one that did not own the counter last wins.
        winner  = (req == 2'b11) ? ~ptr_q : req[1];

        case (state_q)
            IDLE: begin
                count_d = '0;
                gnt_d   = 2'b00;
                if (req != 2'b00) begin
                    state_d = RUN;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    owner_d = winner;
                    tc_d    = winner ? len1 : len0;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    count_d = '0;
                    ptr_d   = owner_q;
                end else if (count_q == tc_q) begin
                    state_d = DONE;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                count_d = '0;
                ptr_d   = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                count_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - randomized and directed bench for counter_arbiter against an interval-timeline model
module tb_counter_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] len0;
    logic [W-1:0] len1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic [W-1:0] count;

    counter_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: an interval is a timeline of tc+2 granted cycles indexed by elapsed.
    bit m_busy = 1'b0;
    int m_own  = 0;
    int m_tc   = 0;
    int m_el   = 0;
    int m_last = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_count();
        if (!m_busy) return 0;
        return (m_el > m_tc) ? m_tc : m_el;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1;
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_own = 1 - m_last;
                else              m_own = req[1] ? 1 : 0;
                m_tc   = m_own ? int'(len1) : int'(len0);
                m_el   = 0;
                m_busy = 1'b1;
            end
        end else if (m_el == m_tc + 1) begin
            m_busy = 1'b0;
            m_last = m_own;
        end else if (!req[m_own]) begin
            m_busy = 1'b0;
            m_last = m_own;
        end else begin
            m_el++;
        end
    endtask

    task automatic compare();
        int e_gnt, e_done;
        e_gnt  = m_busy ? (1 << m_own) : 0;
        e_done = (m_busy && m_el == m_tc + 1) ? (1 << m_own) : 0;
        chk("gnt",   32'(gnt),   32'(e_gnt));
        chk("done",  32'(done),  32'(e_done));
        chk("count", 32'(count), 32'(model_count()));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("done_both", 32'(done == 2'b11), 32'd0);
        chk("done_no_gnt", 32'(done != 2'b00 && gnt == 2'b00), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_to_count(input int target);
        int n;
        n = 0;
        while (!(m_busy && m_el == target) && n < 40) begin
            tick();
            n++;
        end
        chk("reach_count", 32'(m_busy && m_el == target), 32'd1);
    endtask

    initial begin
        int order[$];
        logic [1:0] prev_gnt;
        rst  = 1'b1;
        req  = 2'b00;
        len0 = '0;
        len1 = '0;
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_count", 32'(count), 32'd0);

        // single requester, len 3
        len0 = 4'd3;
        req  = 2'b01;
        repeat (8) tick();
        req = 2'b00;
        repeat (2) tick();

        // contention from reset, grant order recorded from the DUT
        do_reset();
        len0 = 4'd2;
        len1 = 4'd1;
        req  = 2'b11;
        prev_gnt = 2'b00;
        repeat (16) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00) order.push_back(gnt[1] ? 1 : 0);
            prev_gnt = gnt;
        end
        chk("order_len", 32'(order.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("order", 32'(order[i]), 32'(i % 2));
        req = 2'b00;
        repeat (4) tick();

        // zero length
        len1 = 4'd0;
        req  = 2'b10;
        repeat (3) tick();
        req = 2'b00;
        repeat (3) tick();

        // abort at count 4, then contention grants requester 1
        len0 = 4'd9;
        req  = 2'b01;
        run_to_count(4);
        req = 2'b00;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        req = 2'b11;
        tick();
        chk("after_abort_gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        repeat (10) tick();

        // reset mid-run, then requester 0 first
        len1 = 4'd15;
        req  = 2'b10;
        run_to_count(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_gnt", 32'(gnt), 32'd0);
        req = 2'b11;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (4) tick();

        // max length with a late len change
        len0 = 4'd15;
        req  = 2'b01;
        repeat (5) tick();
        len0 = 4'd2;
        repeat (15) tick();
        req = 2'b00;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) req = 2'($urandom);
            len0 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            len1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
